rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_port_arbiter.sv | 119 +++++++++++
 tb/tb_rom_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Single-port ROM arbiter: scan-out reads always win, aux reads fill idle cycles.
// Read data returns one cycle after the address, steered by a registered source tag.
module rom_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 24,
    parameter int STARVE_LIM = 2048
) (
    input  logic          hdmi_clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    input  logic          vid_soon,
    input  logic          aux_req,
    input  logic [AW-1:0] aux_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata,
    output logic [1:0]    owner,
    output logic          aux_starve,
    output logic [15:0]   aux_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        AUX  = 2'd2,
        HOLD = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_VID  = 2'd1,
        SRC_AUX  = 2'd2
    } src_t;

    localparam logic [11:0] LIM = 12'(STARVE_LIM);

    owner_t        dec;
    owner_t        owner_q;
    src_t          tag_q;
    logic [11:0]   wait_cnt;
    logic [11:0]   wait_nxt;
    logic          starve_q;
    logic [15:0]   count_q;
    logic [DW-1:0] vid_hold;
    logic [DW-1:0] aux_hold;

    always_comb begin
        dec = IDLE;
        if (rst)
            dec = IDLE;
        else if (vid_req)
            dec = VID;
        else if (aux_req && vid_soon)
            dec = HOLD;
        else if (aux_req)
            dec = AUX;
    end

    assign aux_gnt = (dec == AUX);

    always_comb begin
        rom_addr = '0;
        case (dec)
            VID:     rom_addr = vid_addr;
            AUX:     rom_addr = aux_addr;
            default: rom_addr = '0;
        endcase
    end

    // Saturate so the flag compare can never be skipped by wraparound.
    always_comb begin
        wait_nxt = '0;
        if (aux_req && !aux_gnt)
            wait_nxt = (wait_cnt == LIM) ? wait_cnt : wait_cnt + 12'd1;
    end

    always_ff @(posedge hdmi_clk) begin
        if (rst) begin
            owner_q  <= IDLE;
            tag_q    <= SRC_NONE;
            wait_cnt <= '0;
            starve_q <= 1'b0;
            count_q  <= '0;
            vid_hold <= '0;
            aux_hold <= '0;
        end else begin
            owner_q  <= dec;
            wait_cnt <= wait_nxt;
            case (dec)
                VID:     tag_q <= SRC_VID;
                AUX:     tag_q <= SRC_AUX;
                default: tag_q <= SRC_NONE;
            endcase
            if (wait_nxt == LIM)
                starve_q <= 1'b1;
            if (aux_gnt)
                count_q <= count_q + 16'd1;
            if (vid_rvalid)
                vid_hold <= rom_data;
            if (aux_rvalid)
                aux_hold <= rom_data;
        end
    end

    // Gate with rst so outputs read as reset values from the first rst cycle.
    assign vid_rvalid = !rst && (tag_q == SRC_VID);
    assign aux_rvalid = !rst && (tag_q == SRC_AUX);
    assign vid_rdata  = rst ? '0 : (vid_rvalid ? rom_data : vid_hold);
    assign aux_rdata  = rst ? '0 : (aux_rvalid ? rom_data : aux_hold);
    assign owner      = rst ? 2'd0 : owner_q;
    assign aux_starve = !rst && starve_q;
    assign aux_count  = rst ? 16'd0 : count_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a one-cycle-latency ROM model
// returning {8'h00, addr}.
module tb_rom_port_arbiter;

    logic        hdmi_clk = 1'b0;
    logic        rst = 1'b1;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = '0;
    logic        vid_soon = 1'b0;
    logic        aux_req = 1'b0;
    logic [15:0] aux_addr = '0;
    logic [15:0] rom_addr;
    logic [23:0] rom_data = '0;
    logic        vid_rvalid;
    logic [23:0] vid_rdata;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [23:0] aux_rdata;
    logic [1:0]  owner;
    logic        aux_starve;
    logic [15:0] aux_count;

    int checks = 0;
    int errors = 0;

    rom_port_arbiter dut (
        .hdmi_clk  (hdmi_clk),
        .rst       (rst),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_soon  (vid_soon),
        .aux_req   (aux_req),
        .aux_addr  (aux_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .vid_rvalid(vid_rvalid),
        .vid_rdata (vid_rdata),
        .aux_gnt   (aux_gnt),
        .aux_rvalid(aux_rvalid),
        .aux_rdata (aux_rdata),
        .owner     (owner),
        .aux_starve(aux_starve),
        .aux_count (aux_count)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    always @(posedge hdmi_clk) rom_data <= {8'h00, rom_addr};

    task automatic do_reset();
        @(negedge hdmi_clk);
        rst = 1'b1;
        vid_req = 1'b0;
        aux_req = 1'b0;
        vid_soon = 1'b0;
        @(negedge hdmi_clk);
        @(negedge hdmi_clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge hdmi_clk);
        rst = 1'b1;
        vid_req = 1'b1;
        vid_addr = 16'h0055;
        aux_req = 1'b1;
        aux_addr = 16'h0077;
        #1;
        checks++;
        if (rom_addr !== 16'h0 || aux_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_port rom_addr=%h gnt=%b want 0/0", rom_addr, aux_gnt);
        end
        checks++;
        if (owner !== 2'd0 || vid_rvalid !== 1'b0 || aux_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_state owner=%0d rv=%b/%b want 0 0/0", owner, vid_rvalid, aux_rvalid);
        end
        checks++;
        if (vid_rdata !== 24'h0 || aux_rdata !== 24'h0 || aux_count !== 16'h0 || aux_starve !== 1'b0) begin
            errors++;
            $display("FAIL rst_regs vrd=%h ard=%h cnt=%h st=%b want zeros", vid_rdata, aux_rdata, aux_count, aux_starve);
        end
        @(negedge hdmi_clk);
        rst = 1'b0;
        vid_req = 1'b0;
        #1;
        checks++;
        if (aux_gnt !== 1'b1 || rom_addr !== 16'h0077) begin
            errors++;
            $display("FAIL first_grant gnt=%b addr=%h want 1/0077", aux_gnt, rom_addr);
        end
        @(negedge hdmi_clk);
        aux_req = 1'b0;
        #1;
        checks++;
        if (aux_rvalid !== 1'b1 || aux_rdata !== 24'h000077 || owner !== 2'd2 || aux_count !== 16'd1) begin
            errors++;
            $display("FAIL first_ret rv=%b rd=%h own=%0d cnt=%0d want 1/000077/2/1", aux_rvalid, aux_rdata, owner, aux_count);
        end
    endtask

    task automatic test_vid_stream();
        for (int i = 0; i < 200; i++) begin
            @(negedge hdmi_clk);
            vid_req = 1'b1;
            vid_addr = 16'(i);
            #1;
            checks++;
            if (rom_addr !== 16'(i) || aux_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL vid_addr i=%0d addr=%h arv=%b want %h/0", i, rom_addr, aux_rvalid, 16'(i));
            end
            if (i > 0) begin
                checks++;
                if (vid_rvalid !== 1'b1 || vid_rdata !== 24'(i - 1)) begin
                    errors++;
                    $display("FAIL vid_ret i=%0d rv=%b rd=%h want 1/%h", i, vid_rvalid, vid_rdata, 24'(i - 1));
                end
            end
        end
        @(negedge hdmi_clk);
        vid_req = 1'b0;
        #1;
        checks++;
        if (vid_rvalid !== 1'b1 || vid_rdata !== 24'd199) begin
            errors++;
            $display("FAIL vid_last rv=%b rd=%h want 1/0000c7", vid_rvalid, vid_rdata);
        end
        @(negedge hdmi_clk);
        #1;
        checks++;
        if (vid_rvalid !== 1'b0 || vid_rdata !== 24'd199) begin
            errors++;
            $display("FAIL vid_hold rv=%b rd=%h want 0/0000c7", vid_rvalid, vid_rdata);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 10; i++) begin
            @(negedge hdmi_clk);
            vid_req = 1'b1;
            vid_addr = 16'(100 + i);
            aux_req = 1'b1;
            aux_addr = 16'h1234;
            #1;
            checks++;
            if (aux_gnt !== 1'b0 || rom_addr !== 16'(100 + i)) begin
                errors++;
                $display("FAIL cont_vid i=%0d gnt=%b addr=%h want 0/%h", i, aux_gnt, rom_addr, 16'(100 + i));
            end
        end
        @(negedge hdmi_clk);
        vid_req = 1'b0;
        #1;
        checks++;
        if (aux_gnt !== 1'b1 || rom_addr !== 16'h1234 || vid_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL cont_gnt gnt=%b addr=%h vrv=%b want 1/1234/1", aux_gnt, rom_addr, vid_rvalid);
        end
        @(negedge hdmi_clk);
        aux_req = 1'b0;
        #1;
        checks++;
        if (aux_rvalid !== 1'b1 || aux_rdata !== 24'h001234 || vid_rvalid !== 1'b0 || aux_count !== 16'd1) begin
            errors++;
            $display("FAIL cont_ret arv=%b rd=%h vrv=%b cnt=%0d want 1/001234/0/1", aux_rvalid, aux_rdata, vid_rvalid, aux_count);
        end
    endtask

    task automatic test_guard();
        @(negedge hdmi_clk);
        aux_req = 1'b1;
        aux_addr = 16'h0abc;
        vid_soon = 1'b1;
        #1;
        checks++;
        if (aux_gnt !== 1'b0 || rom_addr !== 16'h0) begin
            errors++;
            $display("FAIL guard_block gnt=%b addr=%h want 0/0000", aux_gnt, rom_addr);
        end
        @(negedge hdmi_clk);
        #1;
        checks++;
        if (owner !== 2'd3 || aux_gnt !== 1'b0) begin
            errors++;
            $display("FAIL guard_owner own=%0d gnt=%b want 3/0", owner, aux_gnt);
        end
        @(negedge hdmi_clk);
        vid_soon = 1'b0;
        #1;
        checks++;
        if (aux_gnt !== 1'b1 || rom_addr !== 16'h0abc) begin
            errors++;
            $display("FAIL guard_release gnt=%b addr=%h want 1/0abc", aux_gnt, rom_addr);
        end
        @(negedge hdmi_clk);
        aux_req = 1'b0;
        #1;
        checks++;
        if (aux_rvalid !== 1'b1 || aux_rdata !== 24'h000abc || owner !== 2'd2) begin
            errors++;
            $display("FAIL guard_ret rv=%b rd=%h own=%0d want 1/000abc/2", aux_rvalid, aux_rdata, owner);
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 2100; i++) begin
            @(negedge hdmi_clk);
            vid_req = 1'b1;
            vid_addr = 16'h0042;
            aux_req = 1'b1;
            aux_addr = 16'h0f0f;
            #1;
            if (i == 0 || i == 2047) begin
                checks++;
                if (aux_starve !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_early i=%0d st=%b want 0", i, aux_starve);
                end
            end
            if (i == 2048 || i == 2099) begin
                checks++;
                if (aux_starve !== 1'b1) begin
                    errors++;
                    $display("FAIL starve_set i=%0d st=%b want 1", i, aux_starve);
                end
            end
        end
        @(negedge hdmi_clk);
        vid_req = 1'b0;
        #1;
        checks++;
        if (aux_gnt !== 1'b1 || rom_addr !== 16'h0f0f) begin
            errors++;
            $display("FAIL starve_gnt gnt=%b addr=%h want 1/0f0f", aux_gnt, rom_addr);
        end
        @(negedge hdmi_clk);
        aux_req = 1'b0;
        #1;
        @(negedge hdmi_clk);
        #1;
        checks++;
        if (aux_starve !== 1'b1 || aux_count !== 16'd1) begin
            errors++;
            $display("FAIL starve_sticky st=%b cnt=%0d want 1/1", aux_starve, aux_count);
        end
    endtask

    task automatic test_interleave();
        for (int i = 0; i <= 64; i++) begin
            @(negedge hdmi_clk);
            vid_req = (i < 64) && (i % 2 == 1);
            aux_req = (i < 64) && (i % 2 == 0);
            vid_addr = 16'(16'h3000 + i);
            aux_addr = 16'(16'h2000 + i);
            #1;
            checks++;
            if (vid_rvalid === 1'b1 && aux_rvalid === 1'b1) begin
                errors++;
                $display("FAIL il_both i=%0d vrv=1 arv=1 want exclusive", i);
            end
            if (i > 0 && ((i - 1) % 2 == 0)) begin
                checks++;
                if (aux_rvalid !== 1'b1 || vid_rvalid !== 1'b0 || aux_rdata !== 24'(16'h2000 + i - 1)) begin
                    errors++;
                    $display("FAIL il_aux i=%0d arv=%b vrv=%b rd=%h want 1/0/%h", i, aux_rvalid, vid_rvalid, aux_rdata, 24'(16'h2000 + i - 1));
                end
            end
            if (i > 0 && ((i - 1) % 2 == 1)) begin
                checks++;
                if (vid_rvalid !== 1'b1 || aux_rvalid !== 1'b0 || vid_rdata !== 24'(16'h3000 + i - 1)) begin
                    errors++;
                    $display("FAIL il_vid i=%0d vrv=%b arv=%b rd=%h want 1/0/%h", i, vid_rvalid, aux_rvalid, vid_rdata, 24'(16'h3000 + i - 1));
                end
            end
        end
        checks++;
        if (aux_count !== 16'd32) begin
            errors++;
            $display("FAIL il_count cnt=%0d want 32", aux_count);
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge hdmi_clk);
        aux_req = 1'b1;
        aux_addr = 16'h0055;
        #1;
        checks++;
        if (aux_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rif_gnt gnt=%b want 1", aux_gnt);
        end
        @(negedge hdmi_clk);
        aux_req = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (aux_rvalid !== 1'b0 || aux_count !== 16'd0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL rif_suppress arv=%b cnt=%0d own=%0d want 0/0/0", aux_rvalid, aux_count, owner);
        end
        checks++;
        if (aux_rdata !== 24'h0 || vid_rdata !== 24'h0 || aux_starve !== 1'b0) begin
            errors++;
            $display("FAIL rif_regs ard=%h vrd=%h st=%b want 0/0/0", aux_rdata, vid_rdata, aux_starve);
        end
        @(negedge hdmi_clk);
        rst = 1'b0;
        #1;
        checks++;
        if (aux_rvalid !== 1'b0 || vid_rvalid !== 1'b0 || aux_count !== 16'd0) begin
            errors++;
            $display("FAIL rif_after arv=%b vrv=%b cnt=%0d want 0/0/0", aux_rvalid, vid_rvalid, aux_count);
        end
    endtask

    initial begin
        repeat (3) @(negedge hdmi_clk);
        test_reset();
        test_vid_stream();
        do_reset();
        test_contention();
        test_guard();
        do_reset();
        test_starvation();
        do_reset();
        test_interleave();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
